// File: rtl/divider32_seq_pkg.sv
// Shared definitions for the sequential divider: FSM states, default width and
// word offsets on the {remainder, quotient} result bus (same layout as the multiplier bus).
package divider32_seq_pkg;

  localparam int unsigned DivWidth = 32;

  // Word index on the double-width result bus: bus[word*WIDTH +: WIDTH].
  localparam int unsigned QuoWord = 0;
  localparam int unsigned RemWord = 1;

  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivBusy = 2'd1,
    DivFix  = 2'd2,
    DivDone = 2'd3
  } div_state_e;

  // Step counter must hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/divider32_seq_div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, trial-subtract the divisor.
module divider32_seq_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           fits;

  // Since rem_in < divisor, the trial result's top bit is set exactly when it is negative.
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    fits    = ~trial[WIDTH];
    rem_out = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/divider32_seq.sv
// Multi-cycle restoring divider, one quotient bit per cycle, signed/unsigned,
// valid/ready on both sides, result packed as {remainder, quotient}.
module divider32_seq
  import divider32_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               is_signed,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);

  div_state_e state_q, state_d;

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               special_q, special_d;
  logic [2*WIDTH-1:0] out_q, out_d;

  logic               accept;
  logic               s1, s2;
  logic [WIDTH-1:0]   abs1, abs2;
  logic               div_by_zero;
  logic               overflow;
  logic [WIDTH-1:0]   step_rem, step_quo;

  // Operand decode at accept: magnitudes and the two special cases that bypass the iteration.
  always_comb begin
    accept      = (state_q == DivIdle) && in_valid && !flush;
    s1          = is_signed & in1[WIDTH-1];
    s2          = is_signed & in2[WIDTH-1];
    abs1        = s1 ? -in1 : in1;
    abs2        = s2 ? -in2 : in2;
    div_by_zero = (in2 == '0);
    overflow    = is_signed && (in1 == {1'b1, {(WIDTH-1){1'b0}}}) && (in2 == '1);
  end

  divider32_seq_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (div_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // FSM next state; flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DivIdle: if (accept) state_d = (div_by_zero || overflow) ? DivFix : DivBusy;
      DivBusy: if (cnt_q == LastCnt) state_d = DivFix;
      DivFix:  state_d = DivDone;
      DivDone: if (out_ready) state_d = DivIdle;
      default: state_d = DivIdle;
    endcase
    if (flush) state_d = DivIdle;
  end

  // Datapath next state: operand load, iteration, sign fix-up into the output register.
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    special_d = special_q;
    out_d     = out_q;
    unique case (state_q)
      DivIdle: begin
        if (accept) begin
          cnt_d     = '0;
          div_d     = abs2;
          q_neg_d   = s1 ^ s2;
          r_neg_d   = s1;
          special_d = div_by_zero || overflow;
          if (div_by_zero) begin
            quo_d = '1;
            rem_d = in1;
          end else if (overflow) begin
            quo_d = {1'b1, {(WIDTH-1){1'b0}}};
            rem_d = '0;
          end else begin
            quo_d = abs1;
            rem_d = '0;
          end
        end
      end
      DivBusy: begin
        if (cnt_q != LastCnt) begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
        end
      end
      DivFix: begin
        // Special-case results are already final and carry their own signs.
        if (!flush) begin
          if (special_q) begin
            out_d[RemWord*WIDTH +: WIDTH] = rem_q;
            out_d[QuoWord*WIDTH +: WIDTH] = quo_q;
          end else begin
            out_d[RemWord*WIDTH +: WIDTH] = r_neg_q ? -rem_q : rem_q;
            out_d[QuoWord*WIDTH +: WIDTH] = q_neg_q ? -quo_q : quo_q;
          end
        end
      end
      DivDone: ;
      default: ;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DivIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      special_q <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      special_q <= special_d;
      out_q     <= out_d;
    end
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    in_ready  = (state_q == DivIdle);
    out_valid = (state_q == DivDone);
    out       = out_q;
  end

endmodule

// File: tb/tb_divider32_seq.sv
// Directed table plus corner-case sequences and a random pass against a reference model.
module tb_divider32_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        is_signed = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] dut_out;

  int n_tests = 0;
  int n_fail  = 0;

  divider32_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .is_signed (is_signed),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dut_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands for one edge; returns just after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    @(negedge clk);
    check("in_ready_before_issue", {63'd0, in_ready}, 64'd1);
    in1 = a;
    in2 = b;
    is_signed = sgn;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen; ends on a negedge.
  task automatic wait_valid(output int lat, output bit timeout);
    lat = 0;
    timeout = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       output logic [31:0] q, output logic [31:0] r);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  initial begin
    int          lat;
    bit          tmo;
    bit          saw;
    logic [31:0] eq, er, ra, rb;
    logic        rs;

    vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          34};
    vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  34};
    vecs[2]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          34};
    vecs[3]  = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1};
    vecs[4]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1};
    vecs[5]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          34};
    vecs[6]  = '{32'h8000_0000,  32'd2,          1'b0, 32'h4000_0000,  32'd0,          34};
    vecs[7]  = '{32'h8000_0000,  32'd2,          1'b1, 32'hC000_0000,  32'd0,          34};
    vecs[8]  = '{32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  1};
    vecs[9]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          34};
    vecs[10] = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  34};
    vecs[11] = '{32'd3,          32'd10,         1'b0, 32'd0,          32'd3,          34};
    vecs[12] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  34};

    // Reset values.
    #2 rst_n = 1'b0;
    #1;
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_out", dut_out, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sgn);
      wait_valid(lat, tmo);
      check($sformatf("vec%0d_timeout", i), {63'd0, tmo}, 64'd0);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d_quo", i), {32'd0, dut_out[31:0]}, {32'd0, vecs[i].q});
      check($sformatf("vec%0d_rem", i), {32'd0, dut_out[63:32]}, {32'd0, vecs[i].r});
      take_result();
    end

    // Backpressure: result held, no accept even with in_valid asserted.
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_valid(lat, tmo);
    check("bp_timeout", {63'd0, tmo}, 64'd0);
    in1 = 32'd9;
    in2 = 32'd3;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_out_c%0d", c), dut_out, {32'd0, 32'hFFFF_FFFF});
      check($sformatf("bp_valid_c%0d", c), {63'd0, out_valid}, 64'd1);
      check($sformatf("bp_in_ready_c%0d", c), {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    take_result();
    @(negedge clk);
    check("bp_in_ready_after", {63'd0, in_ready}, 64'd1);
    check("bp_valid_after", {63'd0, out_valid}, 64'd0);

    // Flush together with in_valid in IDLE must not accept.
    in1 = 32'd50;
    in2 = 32'd5;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle_no_accept", {63'd0, in_ready}, 64'd1);

    // Flush at BUSY cycle 10.
    issue(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    saw = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("flush_no_valid", {63'd0, saw}, 64'd0);
    issue(32'd100, 32'd7, 1'b0);
    wait_valid(lat, tmo);
    check("post_flush_timeout", {63'd0, tmo}, 64'd0);
    check("post_flush_out", dut_out, {32'd2, 32'd14});
    take_result();

    // Asynchronous reset mid-operation.
    issue(32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_out", dut_out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random operands against the reference model.
    for (int n = 0; n < 20; n++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (n == 3) rb = 32'd0;
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, eq, er);
      issue(ra, rb, rs);
      wait_valid(lat, tmo);
      check($sformatf("rnd%0d_timeout", n), {63'd0, tmo}, 64'd0);
      check($sformatf("rnd%0d_out a=%0h b=%0h s=%0d", n, ra, rb, rs), dut_out, {er, eq});
      take_result();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
